// File: rtl/rr_interconnect.sv
// N-master to single-slave round-robin request/ack arbiter with registered slave
// handshake, abort on request drop and an optional slave-timeout error pulse.
module rr_interconnect #(
    parameter int NUM_MASTERS    = 4,
    parameter int SEL_W          = $clog2(NUM_MASTERS),
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_MASTERS-1:0] M_req,
    output logic [NUM_MASTERS-1:0] M_ack,
    output logic                   S_req,
    input  logic                   S_ack,
    output logic [SEL_W-1:0]       Select,
    output logic                   Busy,
    output logic                   Timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t                   state_q, state_d;
    logic [SEL_W-1:0]         ptr_q, ptr_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic                     sreq_q, sreq_d;
    logic [NUM_MASTERS-1:0]   mack_q, mack_d;
    logic                     terr_q, terr_d;
    logic                     busy_q, busy_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic                     found;
    logic [SEL_W-1:0]         gnt;
    logic [SEL_W-1:0]         idx;
    logic [SEL_W-1:0]         gnt_nxt;

    // First requester at or after the pointer, wrapping modulo NUM_MASTERS.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = SEL_W'((int'(ptr_q) + i) % NUM_MASTERS);
            if (!found && M_req[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
        gnt_nxt = (gnt == LAST_IDX) ? '0 : gnt + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        sreq_d  = sreq_q;
        mack_d  = '0;
        terr_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = gnt;
                    sreq_d  = 1'b1;
                    ptr_d   = gnt_nxt;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Abort beats ack, ack beats timeout.
                if (!M_req[sel_q]) begin
                    sreq_d  = 1'b0;
                    state_d = IDLE;
                end else if (S_ack) begin
                    sreq_d         = 1'b0;
                    mack_d[sel_q]  = 1'b1;
                    state_d        = ACK;
                end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
                    sreq_d  = 1'b0;
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                sreq_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            sreq_q  <= 1'b0;
            mack_q  <= '0;
            terr_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            sreq_q  <= sreq_d;
            mack_q  <= mack_d;
            terr_q  <= terr_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign M_ack       = mack_q;
    assign S_req       = sreq_q;
    assign Select      = sel_q;
    assign Busy        = busy_q;
    assign Timeout_err = terr_q;

endmodule
